mmu_issue_ctrl: RTL and testbench

Command-side sequencer for the MMU valid/group controller. Accepts one operation command (op code, stage, beat count), drives a gap-free `valid_in` burst with stable `op_code`/`stage` into the MMU, and counts the grouped result strobes returned on `valid_out`. When the expected number of results is in, or a drain timeout expires, it reports completion and the result count to the host.

---
 rtl/mmu_pkg.sv | 34 +++
 rtl/mmu_issue_ctrl_if.sv | 32 +++
 rtl/mmu_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_mmu_issue_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared MMU definitions: op codes, issue-controller states and the group-shift
// rule that both the command sequencer and the MMU side must agree on.
`timescale 1ns/1ps
package mmu_pkg;

  localparam logic [2:0] OP_0 = 3'd0;
  localparam logic [2:0] OP_1 = 3'd1;
  localparam logic [2:0] OP_2 = 3'd2;
  localparam logic [2:0] OP_3 = 3'd3;
  localparam logic [2:0] OP_4 = 3'd4;
  localparam logic [2:0] OP_5 = 3'd5;
  localparam logic [2:0] OP_6 = 3'd6;
  localparam logic [2:0] OP_7 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // log2 of the number of operand beats the MMU folds into one result strobe
  function automatic logic [2:0] mmu_group_shift(input logic [2:0] op, input logic [1:0] stage);
    logic [2:0] gs;
    case (op)
      OP_1:    gs = 3'd1 + {1'b0, stage};
      OP_5:    gs = 3'd3 + {1'b0, stage};
      OP_3:    gs = 3'd1;
      default: gs = 3'd0;
    endcase
    return gs;
  endfunction

endpackage

// File: rtl/mmu_issue_ctrl_if.sv
// Host command, MMU operand/result and completion signals of the issue controller.
// The controller uses the slave modport; the host/MMU environment uses master.
`timescale 1ns/1ps
interface mmu_issue_ctrl_if #(
  parameter int BEAT_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [1:0]        cmd_stage;
  logic [BEAT_W-1:0] cmd_beats;
  logic              mmu_valid_in;
  logic [2:0]        mmu_op_code;
  logic [1:0]        mmu_stage;
  logic              src_rd_en;
  logic              mmu_valid_out;
  logic [BEAT_W-1:0] res_count;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_stage, cmd_beats, mmu_valid_out,
    input  cmd_ready, mmu_valid_in, mmu_op_code, mmu_stage, src_rd_en,
           res_count, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_stage, cmd_beats, mmu_valid_out,
    output cmd_ready, mmu_valid_in, mmu_op_code, mmu_stage, src_rd_en,
           res_count, done, err
  );
endinterface

// File: rtl/mmu_issue_ctrl.sv
// Command-side sequencer: issues a gap-free operand burst to the MMU, counts the
// grouped result strobes, and reports completion (or drain timeout) to the host.
`timescale 1ns/1ps
module mmu_issue_ctrl
  import mmu_pkg::*;
#(
  parameter int BEAT_W   = 16,
  parameter int DRAIN_TO = 128
) (
  input  logic             clk,
  input  logic             rst,
  mmu_issue_ctrl_if.slave  bus
);

  localparam int                TMR_W    = $clog2(DRAIN_TO + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(DRAIN_TO - 1);
  localparam logic [BEAT_W-1:0] CNT_MAX  = '1;

  state_t            r_state;
  logic              r_cmd_ready;
  logic              r_valid_in;
  logic              r_done;
  logic              r_err;
  logic [2:0]        r_op;
  logic [1:0]        r_stage;
  logic [BEAT_W-1:0] r_beats_left;
  logic [BEAT_W-1:0] r_expected;
  logic [BEAT_W-1:0] r_res_count;
  logic [TMR_W-1:0]  r_drain_tmr;

  logic [2:0]        w_gs;
  logic [BEAT_W-1:0] w_expected;
  logic              w_counting;
  logic              w_strobe;
  logic              w_overflow;
  logic              w_match;
  logic [BEAT_W-1:0] w_res_next;
  logic [BEAT_W-1:0] w_res_eff;

  assign w_gs       = mmu_group_shift(bus.cmd_op, bus.cmd_stage);
  assign w_expected = (bus.cmd_beats - BEAT_W'(1)) >> w_gs;

  // Strobes only count while a command owns the MMU; IDLE/DONE strobes are stale
  assign w_counting = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign w_strobe   = w_counting && bus.mmu_valid_out;
  assign w_res_next = (r_res_count == CNT_MAX) ? r_res_count : r_res_count + BEAT_W'(1);
  assign w_overflow = w_strobe && (r_res_count >= r_expected);
  assign w_res_eff  = w_strobe ? w_res_next : r_res_count;
  // An overshoot has already raised err, so it ends the drain instead of waiting out the timer
  assign w_match    = (w_res_eff >= r_expected);

  assign bus.cmd_ready    = r_cmd_ready;
  assign bus.mmu_valid_in = r_valid_in;
  assign bus.src_rd_en    = r_valid_in;
  assign bus.mmu_op_code  = r_op;
  assign bus.mmu_stage    = r_stage;
  assign bus.res_count    = r_res_count;
  assign bus.done         = r_done;
  assign bus.err          = r_err;

  // NOTE: all state uses non-blocking assignments so every branch below reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b1;
      r_valid_in   <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_op         <= '0;
      r_stage      <= '0;
      r_beats_left <= '0;
      r_expected   <= '0;
      r_res_count  <= '0;
      r_drain_tmr  <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_strobe) begin
        r_res_count <= w_res_next;
        if (w_overflow) r_err <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_op         <= bus.cmd_op;
            r_stage      <= bus.cmd_stage;
            r_beats_left <= bus.cmd_beats;
            r_res_count  <= '0;
            r_err        <= 1'b0;
            r_cmd_ready  <= 1'b0;
            if (bus.cmd_beats == '0) begin
              r_expected <= '0;
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
            end else begin
              r_expected <= w_expected;
              r_state    <= ST_ISSUE;
              r_valid_in <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          if (r_beats_left == BEAT_W'(1)) begin
            r_state     <= ST_DRAIN;
            r_valid_in  <= 1'b0;
            r_drain_tmr <= '0;
          end else begin
            r_beats_left <= r_beats_left - BEAT_W'(1);
          end
        end

        ST_DRAIN: begin
          if (w_match) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else if (r_drain_tmr == TMR_LAST) begin
            r_err   <= 1'b1;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain_tmr <= r_drain_tmr + TMR_W'(1);
          end
        end

        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_issue_ctrl.sv
// Scoreboard bench for mmu_issue_ctrl: stimulus queues expected bursts and
// completions, a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_mmu_issue_ctrl;

  localparam int BEAT_W   = 16;
  localparam int DRAIN_TO = 128;

  typedef struct {
    int start;
    int len;
    int op;
    int stage;
  } burst_t;

  typedef struct {
    int at;
    int res;
    int err;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   t_acc;

  burst_t burst_q[$];
  done_t  done_q[$];

  mmu_issue_ctrl_if #(.BEAT_W(BEAT_W)) bus ();

  mmu_issue_ctrl #(
    .BEAT_W  (BEAT_W),
    .DRAIN_TO(DRAIN_TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit     in_burst  = 0;
  bit     have_prev = 0;
  bit     rst_since = 0;
  bit     post_done = 0;
  int     b_start;
  int     prev_end;
  burst_t cur;
  done_t  d_cur;

  always @(negedge clk) begin
    if (rst) rst_since = 1;

    if (bus.mmu_valid_in || bus.src_rd_en)
      check("src_rd_en", int'(bus.src_rd_en), int'(bus.mmu_valid_in));

    if (post_done) begin
      post_done = 0;
      if (!rst) begin
        check("ready_after_done", int'(bus.cmd_ready), 1);
        check("done_one_cycle", int'(bus.done), 0);
        check("res_held", int'(bus.res_count), d_cur.res);
        check("err_held", int'(bus.err), d_cur.err);
      end
    end

    if (bus.mmu_valid_in && !in_burst) begin
      in_burst = 1;
      b_start  = cyc;
      if (have_prev && !rst_since)
        check("burst_gap_ge2", int'((cyc - prev_end) >= 2), 1);
      rst_since = 0;
      check("burst_expected", int'(burst_q.size() > 0), 1);
      if (burst_q.size() > 0) begin
        cur = burst_q.pop_front();
        check("burst_start", cyc, cur.start);
      end else begin
        cur = '{cyc, 0, 0, 0};
      end
    end

    if (bus.mmu_valid_in) begin
      check("op_stable", int'(bus.mmu_op_code), cur.op);
      check("stage_stable", int'(bus.mmu_stage), cur.stage);
    end

    if (!bus.mmu_valid_in && in_burst) begin
      in_burst  = 0;
      have_prev = 1;
      prev_end  = cyc;
      check("burst_len", cyc - b_start, cur.len);
    end

    if (bus.done) begin
      check("done_expected", int'(done_q.size() > 0), 1);
      if (done_q.size() > 0) begin
        d_cur = done_q.pop_front();
        check("done_cycle", cyc, d_cur.at);
        check("res_count", int'(bus.res_count), d_cur.res);
        check("err", int'(bus.err), d_cur.err);
        check("ready_low_in_done", int'(bus.cmd_ready), 0);
        post_done = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Tasks start and end just after a rising edge.
  task automatic send(input int op, input int st, input int beats, output int t);
    int waited = 0;
    bus.cmd_op    = 3'(op);
    bus.cmd_stage = 2'(st);
    bus.cmd_beats = 16'(beats);
    bus.cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      waited++;
      if (waited > 400) begin
        $display("FAIL cmd_accept: cmd_ready not seen within 400 cycles (cycle %0d)", cyc);
        $fatal(1, "accept timeout");
      end
    end
    t = cyc;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drive_strobes(input logic [63:0] mask, input int last);
    for (int k = 1; k <= last; k++) begin
      bus.mmu_valid_out = mask[k];
      @(posedge clk);
      #1;
    end
    bus.mmu_valid_out = 1'b0;
  endtask

  task automatic run_cmd(input int op, input int st, input int beats,
                         input logic [63:0] mask, input int last,
                         input int done_off, input int res, input int err);
    int t;
    send(op, st, beats, t);
    if (beats > 0) burst_q.push_back('{t + 1, beats, op, st});
    done_q.push_back('{t + done_off, res, err});
    drive_strobes(mask, last);
  endtask

  function automatic logic [63:0] b(input int k);
    return 64'd1 << k;
  endfunction

  initial begin
    int w;
    bus.cmd_valid     = 1'b0;
    bus.cmd_op        = '0;
    bus.cmd_stage     = '0;
    bus.cmd_beats     = '0;
    bus.mmu_valid_out = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_valid_in", int'(bus.mmu_valid_in), 0);
    check("rst_src_rd_en", int'(bus.src_rd_en), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_res_count", int'(bus.res_count), 0);
    check("rst_op", int'(bus.mmu_op_code), 0);
    check("rst_stage", int'(bus.mmu_stage), 0);
    @(posedge clk);
    #1;

    //       op st beats strobes               last done res err
    run_cmd(0, 0,  4, b(3) | b(4) | b(5),        5,   6,  3, 0);
    run_cmd(1, 2, 17, b(10) | b(18),            18,  19,  2, 0);
    run_cmd(5, 3, 10, 64'd0,                     0,  12,  0, 0);
    run_cmd(3, 0,  0, b(1),                      1,   1,  0, 0);
    run_cmd(3, 0,  5, 64'd0,                     0, 5 + DRAIN_TO + 1, 0, 1);
    run_cmd(3, 0,  5, b(4) | b(5) | b(6),        6,   7,  3, 1);
    run_cmd(5, 0,  9, b(10),                    10,  11,  1, 0);
    run_cmd(7, 1,  2, b(6),                      6,   7,  1, 0);

    // Abort an 8-beat command with a one-cycle reset pulse during T+3
    send(0, 0, 8, t_acc);
    burst_q.push_back('{t_acc + 1, 3, 0, 0});
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid_in", int'(bus.mmu_valid_in), 0);
    check("abort_res_count", int'(bus.res_count), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_cmd_ready", int'(bus.cmd_ready), 1);
    @(posedge clk);
    #1;

    // Back-to-back pair; the first also strobes during its DONE cycle
    run_cmd(1, 0, 4, b(4) | b(6), 6, 6, 1, 0);
    run_cmd(1, 0, 4, b(4),        4, 6, 1, 0);

    w = 0;
    while ((done_q.size() != 0 || burst_q.size() != 0) && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("done_q_drained", done_q.size(), 0);
    check("burst_q_drained", burst_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
